// File: rtl/rt_eoc_monitor.sv
// ---------------------------------------------------------------------------
// rt_eoc_monitor
//
// Multi-channel end-of-computation monitor. Each channel (one per core or
// test thread) posts a status word through a valid/ready write port. Bit 0
// of the word is the EOC flag and the upper bits are the exit code. A
// bit0=0 write is a heartbeat. The block decides between "all enabled
// channels finished" and "per-run watchdog expired". It then reports
// pass/fail/timeout and the number of cycles spent running.
//
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        arm the monitor (only honoured in IDLE)
//   clear_i        leave DONE/TIMEOUT (or abort RUN) back to IDLE
//   ch_en_i        channels required for completion, latched on start
//   wr_valid_i     status write request
//   wr_ready_o     write accepted (high only while running)
//   wr_ch_i        target channel index (one extra bit to catch bad indices)
//   wr_data_i      status word: [0] EOC flag, [DataW-1:1] exit code
//   eoc_o          per-channel EOC seen, sticky within a run
//   exit_code_o    per-channel exit code, channel 0 in the LSBs
//   busy_o         running
//   done_o         all enabled channels reported EOC
//   pass_o         done and every enabled exit code is zero
//   timeout_o      watchdog expired before completion
//   err_o          sticky: write to an out-of-range or disabled channel
//   cycles_o       cycles spent running, saturating
// ---------------------------------------------------------------------------
module rt_eoc_monitor #(
    parameter int NrChannels    = 4,
    parameter int DataW         = 32,
    parameter int TimeoutCycles = 32000,
    parameter int CntW          = 32,
    parameter bit KickEnable    = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              clear_i,
    input  logic [NrChannels-1:0]             ch_en_i,
    input  logic                              wr_valid_i,
    output logic                              wr_ready_o,
    input  logic [$clog2(NrChannels):0]       wr_ch_i,
    input  logic [DataW-1:0]                  wr_data_i,
    output logic [NrChannels-1:0]             eoc_o,
    output logic [NrChannels*(DataW-1)-1:0]   exit_code_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              pass_o,
    output logic                              timeout_o,
    output logic                              err_o,
    output logic [CntW-1:0]                   cycles_o
);

    localparam int ChW   = $clog2(NrChannels) + 1;
    localparam int CodeW = DataW - 1;
    localparam int WdW   = $clog2(TimeoutCycles);
    localparam logic [WdW-1:0] WdLast = WdW'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [NrChannels-1:0]   ch_en_q;
    logic [NrChannels-1:0]   eoc_q;
    logic [CodeW-1:0]        code_q [NrChannels];
    logic [CntW-1:0]         cycles_q;
    logic [WdW-1:0]          wdog_q;
    logic                    err_q;

    logic                    wr_fire;
    logic [NrChannels-1:0]   hit_mask;
    logic                    ch_valid;
    logic [NrChannels-1:0]   eoc_set;
    logic                    kick;
    logic                    err_set;
    logic                    complete;
    logic                    wdog_expire;
    logic                    codes_ok;

    // Write decode. The index is compared against every channel number
    // rather than used to index the enable vector directly, so an
    // out-of-range index simply matches nothing and is flagged as an error.
    always_comb begin
        wr_fire  = wr_valid_i && (state_q == ST_RUN);
        hit_mask = '0;
        for (int i = 0; i < NrChannels; i++) begin
            if (wr_ch_i == ChW'(i)) begin
                hit_mask[i] = 1'b1;
            end
        end
        ch_valid = |(hit_mask & ch_en_q);
        eoc_set  = '0;
        if (wr_fire && wr_data_i[0]) begin
            // Only the first EOC per channel counts; repeats are dropped.
            eoc_set = hit_mask & ch_en_q & ~eoc_q;
        end
        kick        = KickEnable && wr_fire && !wr_data_i[0] && ch_valid;
        err_set     = wr_fire && !ch_valid;
        complete    = (((eoc_q | eoc_set) & ch_en_q) == ch_en_q);
        wdog_expire = (wdog_q == WdLast);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In RUN an abort beats completion, completion beats
    // timeout, and a heartbeat in the expiry cycle keeps the run alive.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (ch_en_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end else if (complete) begin
                    state_d = ST_DONE;
                end else if (wdog_expire && !kick) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (clear_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run status: cleared on start, updated only while running, otherwise
    // frozen so the last run stays readable after clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ch_en_q  <= '0;
            eoc_q    <= '0;
            cycles_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < NrChannels; i++) begin
                code_q[i] <= '0;
            end
        end else if (state_q == ST_IDLE && start_i) begin
            ch_en_q  <= ch_en_i;
            eoc_q    <= '0;
            cycles_q <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < NrChannels; i++) begin
                code_q[i] <= '0;
            end
        end else if (state_q == ST_RUN) begin
            if (cycles_q != {CntW{1'b1}}) begin
                cycles_q <= cycles_q + CntW'(1);
            end
            wdog_q <= kick ? '0 : wdog_q + WdW'(1);
            eoc_q  <= eoc_q | eoc_set;
            for (int i = 0; i < NrChannels; i++) begin
                if (eoc_set[i]) begin
                    code_q[i] <= wr_data_i[DataW-1:1];
                end
            end
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // Pass requires every enabled channel to have reported a zero code.
    always_comb begin
        codes_ok    = 1'b1;
        exit_code_o = '0;
        for (int i = 0; i < NrChannels; i++) begin
            exit_code_o[i*CodeW +: CodeW] = code_q[i];
            if (ch_en_q[i] && (code_q[i] != '0)) begin
                codes_ok = 1'b0;
            end
        end
    end

    assign wr_ready_o = (state_q == ST_RUN);
    assign busy_o     = (state_q == ST_RUN);
    assign done_o     = (state_q == ST_DONE);
    assign timeout_o  = (state_q == ST_TIMEOUT);
    assign pass_o     = (state_q == ST_DONE) && codes_ok;
    assign eoc_o      = eoc_q;
    assign err_o      = err_q;
    assign cycles_o   = cycles_q;

endmodule

// File: tb/tb_rt_eoc_monitor.sv
// ---------------------------------------------------------------------------
// tb_rt_eoc_monitor
//
// Self-checking bench for rt_eoc_monitor (4 channels, 32-bit words,
// 100-cycle watchdog). A behavioural model tracks the run as plain flags
// and counters. A vector table covers the basic flow. Hand-written
// sequences cover reset, pass, timeout, heartbeat and race cases. A random
// phase is then checked cycle by cycle against the model.
// ---------------------------------------------------------------------------
module tb_rt_eoc_monitor;

    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int TO  = 100;
    localparam int CW  = 32;
    localparam int CHW = 3;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  start_i;
    logic                  clear_i;
    logic [NCH-1:0]        ch_en_i;
    logic                  wr_valid_i;
    logic                  wr_ready_o;
    logic [CHW-1:0]        wr_ch_i;
    logic [DW-1:0]         wr_data_i;
    logic [NCH-1:0]        eoc_o;
    logic [NCH*(DW-1)-1:0] exit_code_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  pass_o;
    logic                  timeout_o;
    logic                  err_o;
    logic [CW-1:0]         cycles_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rt_eoc_monitor #(
        .NrChannels   (NCH),
        .DataW        (DW),
        .TimeoutCycles(TO),
        .CntW         (CW),
        .KickEnable   (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .clear_i    (clear_i),
        .ch_en_i    (ch_en_i),
        .wr_valid_i (wr_valid_i),
        .wr_ready_o (wr_ready_o),
        .wr_ch_i    (wr_ch_i),
        .wr_data_i  (wr_data_i),
        .eoc_o      (eoc_o),
        .exit_code_o(exit_code_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .pass_o     (pass_o),
        .timeout_o  (timeout_o),
        .err_o      (err_o),
        .cycles_o   (cycles_o)
    );

    // Reference model: the run is described by three flags and a few counters.
    bit          m_run, m_done, m_tmo, m_err;
    logic [3:0]  m_en, m_eoc;
    logic [30:0] m_code [NCH];
    int unsigned m_cycles;
    int          m_since_kick;

    function automatic bit model_pass();
        bit ok = m_done;
        for (int i = 0; i < NCH; i++) begin
            if (m_en[i] && m_code[i] != 31'd0) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [NCH*(DW-1)-1:0] model_codes();
        logic [NCH*(DW-1)-1:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i*31 +: 31] = m_code[i];
        return v;
    endfunction

    task automatic model_clear_run();
        m_eoc        = 4'h0;
        m_cycles     = 0;
        m_since_kick = 0;
        m_err        = 1'b0;
        for (int i = 0; i < NCH; i++) m_code[i] = 31'd0;
    endtask

    task automatic model_step(input bit rst, input bit start, input bit clear,
                              input logic [3:0] en, input bit valid,
                              input logic [2:0] ch, input logic [31:0] data);
        int  c;
        bit  good;
        bit  kicked;
        bit  expired;
        c = int'(ch);
        good = 1'b0;
        kicked = 1'b0;
        if (rst) begin
            m_run = 0; m_done = 0; m_tmo = 0; m_en = 4'h0;
            model_clear_run();
            return;
        end
        if (m_run) begin
            if (c < NCH) good = m_en[c];
            if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
            if (valid) begin
                if (!good) m_err = 1'b1;
                else if (data[0]) begin
                    if (!m_eoc[c]) begin
                        m_eoc[c]  = 1'b1;
                        m_code[c] = data[31:1];
                    end
                end else kicked = 1'b1;
            end
            expired = (m_since_kick == TO - 1) && !kicked;
            m_since_kick = kicked ? 0 : m_since_kick + 1;
            if (clear) m_run = 0;
            else if ((m_eoc & m_en) == m_en) begin m_run = 0; m_done = 1; end
            else if (expired) begin m_run = 0; m_tmo = 1; end
        end else if (m_done || m_tmo) begin
            if (clear) begin m_done = 0; m_tmo = 0; end
        end else if (start) begin
            m_en = en;
            model_clear_run();
            if (en == 4'h0) m_done = 1;
            else m_run = 1;
        end
    endtask

    task automatic check_field(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, step the model, then
    // settle past the edge before anything is sampled.
    task automatic applyStimulus(input bit rst, input bit start, input bit clear,
                                 input logic [3:0] en, input bit valid,
                                 input logic [2:0] ch, input logic [31:0] data);
        rst_i      = rst;
        start_i    = start;
        clear_i    = clear;
        ch_en_i    = en;
        wr_valid_i = valid;
        wr_ch_i    = ch;
        wr_data_i  = data;
        @(posedge clk);
        model_step(rst, start, clear, en, valid, ch, data);
        #1;
    endtask

    task automatic idle_cycle();
        applyStimulus(0, 0, 0, 4'h0, 0, 3'd0, 32'h0);
    endtask

    task automatic checkOutput();
        check_field("ready",     128'(wr_ready_o),  128'(m_run));
        check_field("busy",      128'(busy_o),      128'(m_run));
        check_field("done",      128'(done_o),      128'(m_done));
        check_field("timeout",   128'(timeout_o),   128'(m_tmo));
        check_field("pass",      128'(pass_o),      128'(model_pass()));
        check_field("err",       128'(err_o),       128'(m_err));
        check_field("eoc",       128'(eoc_o),       128'(m_eoc));
        check_field("exit_code", 128'(exit_code_o), 128'(model_codes()));
        check_field("cycles",    128'(cycles_o),    128'(m_cycles));
    endtask

    typedef struct {
        bit          rst;
        bit          start;
        bit          clear;
        logic [3:0]  en;
        bit          valid;
        logic [2:0]  ch;
        logic [31:0] data;
        bit          e_busy;
        bit          e_done;
        bit          e_pass;
        bit          e_tmo;
        bit          e_err;
    } vec_t;

    vec_t vecs [15];

    initial begin
        bit tmo_seen;
        int n;

        vecs[0]  = '{1, 0, 0, 4'h0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 4'h3, 0, 3'd0, 32'h0, 1, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 0, 4'h0, 1, 3'd1, 32'h7, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 4'h0, 1, 3'd5, 32'h1, 1, 0, 0, 0, 1};
        vecs[4]  = '{0, 0, 0, 4'h0, 1, 3'd0, 32'h1, 0, 1, 0, 0, 1};
        vecs[5]  = '{0, 0, 0, 4'h0, 0, 3'd0, 32'h0, 0, 1, 0, 0, 1};
        vecs[6]  = '{0, 1, 1, 4'h1, 0, 3'd0, 32'h0, 0, 0, 0, 0, 1};
        vecs[7]  = '{0, 1, 0, 4'h1, 0, 3'd0, 32'h0, 1, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 4'h0, 1, 3'd0, 32'h4, 1, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 4'h0, 1, 3'd0, 32'h1, 0, 1, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 4'h0, 1, 3'd0, 32'h5, 0, 1, 1, 0, 0};
        vecs[11] = '{0, 0, 1, 4'h0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 1, 0, 4'h0, 0, 3'd0, 32'h0, 0, 1, 1, 0, 0};
        vecs[13] = '{0, 0, 1, 4'h0, 0, 3'd0, 32'h0, 0, 0, 0, 0, 0};
        vecs[14] = '{0, 0, 0, 4'h0, 1, 3'd2, 32'h1, 0, 0, 0, 0, 0};

        applyStimulus(1, 0, 0, 4'h0, 0, 3'd0, 32'h0);
        applyStimulus(1, 0, 0, 4'h0, 0, 3'd0, 32'h0);
        checkOutput();

        // Table-driven basic flow.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].clear, vecs[i].en,
                          vecs[i].valid, vecs[i].ch, vecs[i].data);
            checkOutput();
            check_field("vec_busy",    128'(busy_o),    128'(vecs[i].e_busy));
            check_field("vec_done",    128'(done_o),    128'(vecs[i].e_done));
            check_field("vec_pass",    128'(pass_o),    128'(vecs[i].e_pass));
            check_field("vec_timeout", 128'(timeout_o), 128'(vecs[i].e_tmo));
            check_field("vec_err",     128'(err_o),     128'(vecs[i].e_err));
        end
        check_field("vec_ch1_code_after_fail_run", 128'(m_code[1]), 128'(0));

        // Reset held for three cycles in the middle of a run.
        applyStimulus(0, 1, 0, 4'hF, 0, 3'd0, 32'h0);
        applyStimulus(0, 0, 0, 4'h0, 1, 3'd0, 32'h7);
        applyStimulus(0, 0, 0, 4'h0, 1, 3'd5, 32'h1);
        check_field("pre_reset_busy", 128'(busy_o), 128'(1));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 4'h0, 0, 3'd0, 32'h0);
            check_field("rst_ready",  128'(wr_ready_o),  128'(0));
            check_field("rst_busy",   128'(busy_o),      128'(0));
            check_field("rst_err",    128'(err_o),       128'(0));
            check_field("rst_eoc",    128'(eoc_o),       128'(0));
            check_field("rst_code",   128'(exit_code_o), 128'(0));
            check_field("rst_cycles", 128'(cycles_o),    128'(0));
        end

        // Pass: EOC on channels 0..3 in run cycles 10, 20, 30, 40.
        applyStimulus(0, 1, 0, 4'hF, 0, 3'd0, 32'h0);
        for (int i = 0; i <= 40; i++) begin
            if (i % 10 == 0 && i > 0) applyStimulus(0, 0, 0, 4'h0, 1, 3'(i / 10 - 1), 32'h1);
            else idle_cycle();
            checkOutput();
        end
        check_field("pass_done",   128'(done_o),   128'(1));
        check_field("pass_pass",   128'(pass_o),   128'(1));
        check_field("pass_cycles", 128'(cycles_o), 128'(41));

        // Timeout with no writes: expires exactly TO cycles after start.
        applyStimulus(0, 0, 1, 4'h0, 0, 3'd0, 32'h0);
        applyStimulus(0, 1, 0, 4'h1, 0, 3'd0, 32'h0);
        n = 0;
        while (!timeout_o && n < 200) begin
            idle_cycle();
            checkOutput();
            n++;
        end
        check_field("timeout_latency", 128'(n),         128'(100));
        check_field("timeout_flag",    128'(timeout_o), 128'(1));
        check_field("timeout_cycles",  128'(cycles_o),  128'(100));
        check_field("timeout_done",    128'(done_o),    128'(0));

        // Heartbeat every 90 cycles keeps a 500-cycle run alive.
        applyStimulus(0, 0, 1, 4'h0, 0, 3'd0, 32'h0);
        applyStimulus(0, 1, 0, 4'h1, 0, 3'd0, 32'h0);
        tmo_seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (i % 90 == 89) applyStimulus(0, 0, 0, 4'h0, 1, 3'd0, 32'h0);
            else idle_cycle();
            if (timeout_o) tmo_seen = 1'b1;
        end
        check_field("kick_no_timeout", 128'(tmo_seen), 128'(0));
        applyStimulus(0, 0, 0, 4'h0, 1, 3'd0, 32'h1);
        checkOutput();
        check_field("kick_done",   128'(done_o),   128'(1));
        check_field("kick_cycles", 128'(cycles_o), 128'(501));

        // Final EOC lands in the watchdog expiry cycle: completion wins.
        applyStimulus(0, 0, 1, 4'h0, 0, 3'd0, 32'h0);
        applyStimulus(0, 1, 0, 4'h1, 0, 3'd0, 32'h0);
        for (int i = 0; i < 99; i++) idle_cycle();
        applyStimulus(0, 0, 0, 4'h0, 1, 3'd0, 32'h1);
        checkOutput();
        check_field("race_done",    128'(done_o),    128'(1));
        check_field("race_timeout", 128'(timeout_o), 128'(0));

        // Heartbeat in the expiry cycle: the kick wins and the run continues.
        applyStimulus(0, 0, 1, 4'h0, 0, 3'd0, 32'h0);
        applyStimulus(0, 1, 0, 4'h1, 0, 3'd0, 32'h0);
        for (int i = 0; i < 99; i++) idle_cycle();
        applyStimulus(0, 0, 0, 4'h0, 1, 3'd0, 32'h0);
        checkOutput();
        check_field("kick_race_busy", 128'(busy_o), 128'(1));

        // Repeated EOC on channel 0: the first exit code is kept.
        applyStimulus(0, 0, 1, 4'h0, 0, 3'd0, 32'h0);
        applyStimulus(0, 1, 0, 4'h3, 0, 3'd0, 32'h0);
        applyStimulus(0, 0, 0, 4'h0, 1, 3'd0, 32'h1);
        applyStimulus(0, 0, 0, 4'h0, 1, 3'd0, 32'h5);
        check_field("repeat_code0", 128'(exit_code_o[30:0]), 128'(0));
        applyStimulus(0, 0, 0, 4'h0, 1, 3'd1, 32'h1);
        checkOutput();
        check_field("repeat_pass", 128'(pass_o), 128'(1));

        // Randomised traffic checked against the model every cycle.
        applyStimulus(1, 0, 0, 4'h0, 0, 3'd0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] d;
            d = $urandom;
            if ($urandom_range(0, 1) == 1) d[31:1] = 31'd0;
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 39) == 0,
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 2) != 0,
                          3'($urandom_range(0, 7)),
                          d);
            checkOutput();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
